// File: rtl/attn_pkg.sv
// Shared defaults and types for the attention softmax datapath stages.
package attn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_LANES  = 4;
  localparam int ROW_WORDS  = 32;
  localparam int BEATS      = ROW_WORDS / NUM_LANES;
  localparam int ACC_WIDTH  = 24;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] beat_t;

endpackage

// File: rtl/exp_row_buffer.sv
// One softmax row of exponent beats: synchronous write, asynchronous read flop array.
module exp_row_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem_reg[rd_ptr];

endmodule

// File: rtl/mode3_exp_sum.sv
// Softmax row-sum stage: accumulates a row of exponents, then presents the sum
// and replays the buffered row to the normalise stage.
module mode3_exp_sum #(
  parameter int DATA_WIDTH = attn_pkg::DATA_WIDTH,
  parameter int NUM_LANES  = attn_pkg::NUM_LANES,
  parameter int ROW_WORDS  = attn_pkg::ROW_WORDS,
  parameter int ACC_WIDTH  = attn_pkg::ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] inp0,
  input  logic [DATA_WIDTH-1:0] inp1,
  input  logic [DATA_WIDTH-1:0] inp2,
  input  logic [DATA_WIDTH-1:0] inp3,
  output logic                  sum_valid,
  output logic [ACC_WIDTH-1:0]  sum_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] outp0,
  output logic [DATA_WIDTH-1:0] outp1,
  output logic [DATA_WIDTH-1:0] outp2,
  output logic [DATA_WIDTH-1:0] outp3,
  output logic                  out_last
);

  import attn_pkg::*;

  localparam int BEATS_ROW = ROW_WORDS / NUM_LANES;
  localparam int PTR_W     = (BEATS_ROW > 1) ? $clog2(BEATS_ROW) : 1;
  localparam int BEAT_W    = NUM_LANES * DATA_WIDTH;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BEATS_ROW - 1);

  // The accumulator must hold a full row of maximum lane values without wrapping.
  if (ACC_WIDTH < DATA_WIDTH + $clog2(ROW_WORDS)) begin : g_bad_acc_width
    $error("mode3_exp_sum: ACC_WIDTH too narrow for ROW_WORDS x DATA_WIDTH");
  end
  if ((ROW_WORDS % NUM_LANES) != 0) begin : g_bad_row_words
    $error("mode3_exp_sum: ROW_WORDS must be a multiple of NUM_LANES");
  end
  if (NUM_LANES != 4) begin : g_bad_lanes
    $error("mode3_exp_sum: NUM_LANES is fixed at 4");
  end

  state_t               state_reg, state_next;
  logic [ACC_WIDTH-1:0] acc_reg, acc_next;
  logic [ACC_WIDTH-1:0] sum_reg, sum_next;
  logic [PTR_W-1:0]     beat_cnt_reg, beat_cnt_next;
  logic [PTR_W-1:0]     rd_ptr_reg, rd_ptr_next;

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] in_lanes;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] rd_lanes;
  logic [ACC_WIDTH-1:0] lane_sum [NUM_LANES+1];
  logic [ACC_WIDTH-1:0] beat_sum;
  logic                 accept;

  assign in_lanes = {inp3, inp2, inp1, inp0};

  assign lane_sum[0] = '0;
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_add
    assign lane_sum[gi+1] = lane_sum[gi] + ACC_WIDTH'(in_lanes[gi]);
  end
  assign beat_sum = lane_sum[NUM_LANES];

  assign accept = in_valid && (state_reg == ACCUM);

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    sum_next      = sum_reg;
    beat_cnt_next = beat_cnt_reg;
    rd_ptr_next   = rd_ptr_reg;
    case (state_reg)
      ACCUM: begin
        if (accept) begin
          if (beat_cnt_reg == LAST_PTR) begin
            sum_next      = acc_reg + beat_sum;
            acc_next      = '0;
            beat_cnt_next = '0;
            rd_ptr_next   = '0;
            state_next    = DRAIN;
          end else begin
            acc_next      = acc_reg + beat_sum;
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_ptr_reg == LAST_PTR) begin
            rd_ptr_next = '0;
            state_next  = ACCUM;
          end else begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
          end
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ACCUM;
      acc_reg      <= '0;
      sum_reg      <= '0;
      beat_cnt_reg <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      sum_reg      <= sum_next;
      beat_cnt_reg <= beat_cnt_next;
      rd_ptr_reg   <= rd_ptr_next;
    end
  end

  exp_row_buffer #(
    .DEPTH (BEATS_ROW),
    .WIDTH (BEAT_W),
    .PTR_W (PTR_W)
  ) u_row_buffer (
    .clk    (clk),
    .we     (accept),
    .wr_ptr (beat_cnt_reg),
    .wdata  (in_lanes),
    .rd_ptr (rd_ptr_reg),
    .rdata  (rd_lanes)
  );

  // Handshake outputs come from state alone, never from same-cycle inputs.
  assign in_ready  = (state_reg == ACCUM);
  assign sum_valid = (state_reg == DRAIN);
  assign out_valid = (state_reg == DRAIN);
  assign out_last  = (state_reg == DRAIN) && (rd_ptr_reg == LAST_PTR);
  assign sum_out   = sum_reg;
  assign outp0     = rd_lanes[0];
  assign outp1     = rd_lanes[1];
  assign outp2     = rd_lanes[2];
  assign outp3     = rd_lanes[3];

endmodule

// File: tb/tb_mode3_exp_sum.sv
// Directed bench for mode3_exp_sum with a scoreboard of expected sums and replay beats.
module tb_mode3_exp_sum;
  import attn_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [15:0] inp0, inp1, inp2, inp3;
  logic        in_ready, sum_valid, out_valid, out_last;
  logic [23:0] sum_out;
  logic [15:0] outp0, outp1, outp2, outp3;

  int total = 0;
  int bad   = 0;

  beat_t       beat_q[$];
  logic [23:0] sum_q[$];
  beat_t       row[BEATS];

  mode3_exp_sum dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp0      (inp0),
    .inp1      (inp1),
    .inp2      (inp2),
    .inp3      (inp3),
    .sum_valid (sum_valid),
    .sum_out   (sum_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outp0     (outp0),
    .outp1     (outp1),
    .outp2     (outp2),
    .outp3     (outp3),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int k = 0; k < BEATS; k++)
      for (int l = 0; l < NUM_LANES; l++) row[k][l] = v;
  endtask

  // Drives row[] one beat per cycle (optionally with an idle cycle before each beat).
  task automatic feed_row(input bit gapped, input string name);
    logic [23:0] s;
    s = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (gapped) begin
        @(negedge clk);
        in_valid = 1'b0;
        inp0 = 16'hdead; inp1 = 16'hbeef; inp2 = 16'hdead; inp3 = 16'hbeef;
      end
      @(negedge clk);
      chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      {inp3, inp2, inp1, inp0} = row[k];
      beat_q.push_back(row[k]);
      for (int l = 0; l < NUM_LANES; l++) s += 24'(row[k][l]);
    end
    sum_q.push_back(s);
    $display("row %s fed: expected sum=%0h", name, s);
  endtask

  // Consumes one row's replay; optional stall (with stray in_valid pulse) before beat stall_k.
  task automatic drain_row(input string name, input int stall_k, input int stall_len,
                           input bit hold_valid, input beat_t hold_beat);
    logic [23:0] exp_s;
    beat_t       exp_b;
    logic [63:0] seen_b;
    exp_s = sum_q.pop_front();
    for (int k = 0; k < BEATS; k++) begin
      @(negedge clk);
      in_valid = hold_valid;
      {inp3, inp2, inp1, inp0} = hold_beat;
      out_ready = 1'b1;
      exp_b = beat_q.pop_front();
      chk({name, "_out_valid"}, 64'(out_valid), 64'd1);
      chk({name, "_sum_valid"}, 64'(sum_valid), 64'd1);
      chk({name, "_sum_out"}, 64'(sum_out), 64'(exp_s));
      chk({name, "_in_ready_drain"}, 64'(in_ready), 64'd0);
      chk({name, "_outp"}, {outp3, outp2, outp1, outp0}, exp_b);
      chk({name, "_out_last"}, 64'(out_last), 64'(k == BEATS - 1));
      $display("replay %s beat %0d: data=%h last=%0b sum=%0h", name, k,
               {outp3, outp2, outp1, outp0}, out_last, sum_out);
      if (k == stall_k) begin
        out_ready = 1'b0;
        seen_b = {outp3, outp2, outp1, outp0};
        for (int c = 0; c < stall_len; c++) begin
          @(negedge clk);
          chk({name, "_stall_outp"}, {outp3, outp2, outp1, outp0}, seen_b);
          chk({name, "_stall_last"}, 64'(out_last), 64'(k == BEATS - 1));
          chk({name, "_stall_sum"}, 64'(sum_out), 64'(exp_s));
          chk({name, "_stall_in_ready"}, 64'(in_ready), 64'd0);
          chk({name, "_stall_out_valid"}, 64'(out_valid), 64'd1);
          in_valid = (c == 1);
          {inp3, inp2, inp1, inp0} = {4{16'h7777}};
        end
        in_valid = hold_valid;
        {inp3, inp2, inp1, inp0} = hold_beat;
        out_ready = 1'b1;
      end
    end
  endtask

  initial begin
    beat_t zero_b;
    zero_b    = '0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    {inp3, inp2, inp1, inp0} = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_sum_valid", 64'(sum_valid), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_last", 64'(out_last), 64'd0);
    chk("reset_sum_out", 64'(sum_out), 64'd0);

    // Full-scale row: 32 x 1.0
    fill_const(16'h1000);
    feed_row(1'b0, "full");
    drain_row("full", -1, 0, 1'b0, zero_b);

    // Ramp row 1..32
    for (int k = 0; k < BEATS; k++)
      for (int l = 0; l < NUM_LANES; l++) row[k][l] = 16'(4 * k + l + 1);
    feed_row(1'b0, "ramp");
    drain_row("ramp", -1, 0, 1'b0, zero_b);

    // Gapped input
    for (int k = 0; k < BEATS; k++)
      for (int l = 0; l < NUM_LANES; l++) row[k][l] = 16'($urandom_range(16'h0001, 16'hffff));
    feed_row(1'b1, "gapped");
    drain_row("gapped", -1, 0, 1'b0, zero_b);

    // Stall mid-drain with a stray in_valid pulse
    for (int k = 0; k < BEATS; k++)
      for (int l = 0; l < NUM_LANES; l++) row[k][l] = 16'(16'h0100 + 16 * k + l);
    feed_row(1'b0, "stall");
    drain_row("stall", 2, 5, 1'b0, zero_b);

    // Back-to-back rows A then B with in_valid held high
    fill_const(16'h1000);
    feed_row(1'b0, "rowA");
    fill_const(16'h0400);
    drain_row("rowA", -1, 0, 1'b1, row[0]);
    feed_row(1'b0, "rowB");
    drain_row("rowB", -1, 0, 1'b0, zero_b);

    // Reset after 5 beats of 0x0800
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      {inp3, inp2, inp1, inp0} = {4{16'h0800}};
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    chk("midreset_sum_valid", 64'(sum_valid), 64'd0);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_sum_out", 64'(sum_out), 64'd0);
    $display("mid-row reset applied");

    // Underflow codes sum like ordinary values
    fill_const(16'h0001);
    feed_row(1'b0, "ones");
    drain_row("ones", -1, 0, 1'b0, zero_b);

    @(negedge clk);
    chk("final_in_ready", 64'(in_ready), 64'd1);
    chk("final_queue_empty", 64'(beat_q.size() + sum_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
